lcd_spi_rx: RTL and testbench
=============================

LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 Parameter H_RES, default 240: panel width; reset column end is H_RES-1.
REQ-002 Parameter V_RES, default 320: panel height; reset page end is V_RES-1.
REQ-003 i_clk  input  1  system clock, single clock domain; at least 4x the i_sclk frequency.
REQ-004 i_rst  input  1  reset, synchronous to i_clk, active-high.
REQ-005 i_sclk  input  1  SPI serial clock from the display driver; idle low; asynchronous.
REQ-006 i_mosi  input  1  SPI data; MSB first; sampled on the i_sclk rising edge.
REQ-007 i_cs  input  1  chip select, active-low.
REQ-008 i_dc  input  1  0 = command byte, 1 = data byte.
REQ-009 i_lcd_rst  input  1  display reset from the driver, active-low.
REQ-010 o_byte  output  8  last received byte.
REQ-011 o_byte_valid  output  1  one-cycle strobe; o_byte and o_byte_is_data are valid.
REQ-012 o_byte_is_data  output  1  i_dc value captured with the byte.
REQ-013 o_pix_valid  output  1  one-cycle pixel write strobe.
REQ-014 o_pix_x / o_pix_y  output  16 each  pixel column and page.
REQ-015 o_pix_color  output  16  RGB565 pixel value, {high byte, low byte}.
REQ-016 o_err  output  1  sticky flag: CS deasserted mid-byte; cleared only by i_rst.

Function
REQ-017 i_sclk, i_mosi, i_cs and i_dc SHALL each pass through a 2-flop synchronizer; a rising edge SHALL be detected as synced sclk = 1 with the previous synced sclk = 0.
REQ-018 On each detected edge with synced cs = 0, the shift register SHALL shift in synced mosi, and the 3-bit bit counter SHALL increment.
REQ-019 On the 8th edge, o_byte, o_byte_is_data (synced dc at that edge) and o_byte_valid SHALL register in the following cycle, and the bit counter SHALL wrap to 0.
REQ-020 Synced cs = 1 SHALL clear the bit counter; if the counter was nonzero, the partial byte SHALL be discarded and o_err SHALL set.
REQ-021 Decoder FSM states: IDLE, CASET, PASET, RAMWR, SKIP; the FSM advances only on o_byte_valid.
REQ-022 A command byte SHALL abort any state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR, any other value -> SKIP.
REQ-023 CASET SHALL take 4 data bytes as SC[15:8], SC[7:0], EC[15:8], EC[7:0], update SC/EC only on the 4th byte, then go to SKIP; PASET SHALL do the same for SP/EP.
REQ-024 Entry to RAMWR SHALL load x = SC, y = SP and clear the byte phase.
REQ-025 In RAMWR, data bytes SHALL alternate high then low; on a low byte, o_pix_valid SHALL pulse 1 cycle after that byte's o_byte_valid, carrying the current x, y and color.
REQ-026 After each pixel: if x != EC, x+1; else x = SC and, if y != EP, y+1; else y = SP (frame wrap).
REQ-027 A command arriving between a high and a low byte SHALL drop the pending high byte without a pixel strobe.
REQ-028 Data bytes in IDLE or SKIP SHALL be ignored; SC > EC or SP > EP SHALL be accepted, with wrap occurring only on equality.

Reset
REQ-029 i_rst SHALL clear o_byte, o_byte_valid, o_byte_is_data, o_pix_valid, o_pix_x, o_pix_y, o_pix_color, o_err, the bit counter and the shift register, and SHALL set the FSM to IDLE, SC = 0, EC = H_RES-1, SP = 0, EP = V_RES-1.
REQ-030 Synced i_lcd_rst = 0 SHALL reset the FSM, windows, bit counter and pixel outputs as REQ-029 but SHALL leave o_err unchanged.
REQ-031 Reset mid-byte or mid-pixel SHALL discard the partial data, and no strobe SHALL follow.

Verification
REQ-032 Send cmd 0xA5 (dc = 0) -> one o_byte_valid, o_byte = 0xA5, o_byte_is_data = 0; no o_pix_valid.
REQ-033 Send 0x2A, then 00 0A 00 0B; 0x2B, then 00 05 00 06; 0x2C, then 5 pixels F8 00 -> o_pix_valid 5x at (10,5), (11,5), (10,6), (11,6), (10,5), color 0xF800.
REQ-034 After reset, send 0x2C, then 12 34 -> pixel at (0,0), color 0x1234.
REQ-035 Raise CS after 3 bits, then send a full 0x2C -> o_err = 1; the next byte decodes as 0x2C with no corruption.
REQ-036 Send 0x2C, then 0xAB, then cmd 0x00, then data 0x12 0x34 -> no o_pix_valid.
REQ-037 Pulse i_rst during a RAMWR stream -> all outputs 0 the next cycle; the window returns to (0..239, 0..319).

Source files
------------

// File: rtl/lcd_spi_rx.sv
// SPI receiver for an ILI9341-style display bus: deserialises bytes from an
// oversampled SPI link and decodes CASET/PASET/RAMWR into pixel writes.
module lcd_spi_rx #(
    parameter int H_RES = 240,
    parameter int V_RES = 320
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_cs,
    input  logic        i_dc,
    input  logic        i_lcd_rst,
    output logic [7:0]  o_byte,
    output logic        o_byte_valid,
    output logic        o_byte_is_data,
    output logic        o_pix_valid,
    output logic [15:0] o_pix_x,
    output logic [15:0] o_pix_y,
    output logic [15:0] o_pix_color,
    output logic        o_err,
    output logic [2:0]  o_dbg_state
);
    typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

    localparam logic [15:0] EC_RST = 16'(H_RES - 1);
    localparam logic [15:0] EP_RST = 16'(V_RES - 1);
    // Synchronizer bit order {lcd_rst, dc, cs, mosi, sclk}; reset to the idle levels.
    localparam logic [4:0] SYNC_IDLE = 5'b10100;

    logic [4:0] meta_q, sync_q;
    logic       sclk_prev_q;
    logic [2:0] bitcnt_q;
    logic [7:0] shift_q;
    logic [7:0] byte_q;
    logic       byte_valid_q, byte_is_data_q, err_q;

    logic sclk_s, mosi_s, cs_s, dc_s, lrst_s, rise;
    assign sclk_s = sync_q[0];
    assign mosi_s = sync_q[1];
    assign cs_s   = sync_q[2];
    assign dc_s   = sync_q[3];
    assign lrst_s = sync_q[4];
    assign rise   = sclk_s & ~sclk_prev_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta_q         <= SYNC_IDLE;
            sync_q         <= SYNC_IDLE;
            sclk_prev_q    <= 1'b0;
            bitcnt_q       <= 3'd0;
            shift_q        <= 8'd0;
            byte_q         <= 8'd0;
            byte_valid_q   <= 1'b0;
            byte_is_data_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            meta_q       <= {i_lcd_rst, i_dc, i_cs, i_mosi, i_sclk};
            sync_q       <= meta_q;
            sclk_prev_q  <= sclk_s;
            byte_valid_q <= 1'b0;
            if (!lrst_s) begin
                bitcnt_q <= 3'd0;
                shift_q  <= 8'd0;
            end else if (cs_s) begin
                // A deselect with bits already shifted means the byte was truncated.
                bitcnt_q <= 3'd0;
                if (bitcnt_q != 3'd0) err_q <= 1'b1;
            end else if (rise) begin
                shift_q  <= {shift_q[6:0], mosi_s};
                bitcnt_q <= bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    byte_q         <= {shift_q[6:0], mosi_s};
                    byte_is_data_q <= dc_s;
                    byte_valid_q   <= 1'b1;
                end
            end
        end
    end

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] tmp_q, tmp_d;
    logic [15:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic        pix_valid_q, pix_valid_d;
    logic [15:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d, color_q, color_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmp_d       = tmp_q;
        sc_d        = sc_q;
        ec_d        = ec_q;
        sp_d        = sp_q;
        ep_d        = ep_q;
        x_d         = x_q;
        y_d         = y_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        pix_valid_d = 1'b0;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        color_d     = color_q;
        if (byte_valid_q) begin
            if (!byte_is_data_q) begin
                // Any command aborts the current state and drops a pending high byte.
                cnt_d   = 2'd0;
                phase_d = 1'b0;
                case (byte_q)
                    8'h2A:   state_d = S_CASET;
                    8'h2B:   state_d = S_PASET;
                    8'h2C: begin
                        state_d = S_RAMWR;
                        x_d     = sc_q;
                        y_d     = sp_q;
                    end
                    default: state_d = S_SKIP;
                endcase
            end else begin
                case (state_q)
                    S_CASET, S_PASET: begin
                        tmp_d = {tmp_q[15:0], byte_q};
                        cnt_d = cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (state_q == S_CASET) begin
                                sc_d = tmp_q[23:8];
                                ec_d = {tmp_q[7:0], byte_q};
                            end else begin
                                sp_d = tmp_q[23:8];
                                ep_d = {tmp_q[7:0], byte_q};
                            end
                            state_d = S_SKIP;
                        end
                    end
                    S_RAMWR: begin
                        if (!phase_q) begin
                            hi_d    = byte_q;
                            phase_d = 1'b1;
                        end else begin
                            phase_d     = 1'b0;
                            pix_valid_d = 1'b1;
                            pix_x_d     = x_q;
                            pix_y_d     = y_q;
                            color_d     = {hi_q, byte_q};
                            if (x_q != ec_q) begin
                                x_d = x_q + 16'd1;
                            end else begin
                                x_d = sc_q;
                                y_d = (y_q != ep_q) ? y_q + 16'd1 : sp_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || !lrst_s) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            tmp_q       <= 24'd0;
            sc_q        <= 16'd0;
            ec_q        <= EC_RST;
            sp_q        <= 16'd0;
            ep_q        <= EP_RST;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 16'd0;
            pix_y_q     <= 16'd0;
            color_q     <= 16'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmp_q       <= tmp_d;
            sc_q        <= sc_d;
            ec_q        <= ec_d;
            sp_q        <= sp_d;
            ep_q        <= ep_d;
            x_q         <= x_d;
            y_q         <= y_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            color_q     <= color_d;
        end
    end

    assign o_byte         = byte_q;
    assign o_byte_valid   = byte_valid_q;
    assign o_byte_is_data = byte_is_data_q;
    assign o_pix_valid    = pix_valid_q;
    assign o_pix_x        = pix_x_q;
    assign o_pix_y        = pix_y_q;
    assign o_pix_color    = color_q;
    assign o_err          = err_q;
    assign o_dbg_state    = state_q;
endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: byte/pixel vector table plus directed sequences for
// error, display reset, system reset mid-stream and window wrap.
module tb_lcd_spi_rx;
    logic        clk, rst, sclk, mosi, cs, dc, lcd_rst;
    logic [7:0]  o_byte;
    logic        o_byte_valid, o_byte_is_data, o_pix_valid, o_err;
    logic [15:0] o_pix_x, o_pix_y, o_pix_color;
    logic [2:0]  o_dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [47:0] exp_q[$];
    logic [8:0]  exp_byte_q[$];

    typedef struct {
        logic        dc;
        logic [7:0]  b;
        logic        pix;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] c;
    } vec_t;
    vec_t vecs[$];

    lcd_spi_rx dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_cs(cs),
        .i_dc(dc), .i_lcd_rst(lcd_rst), .o_byte(o_byte), .o_byte_valid(o_byte_valid),
        .o_byte_is_data(o_byte_is_data), .o_pix_valid(o_pix_valid), .o_pix_x(o_pix_x),
        .o_pix_y(o_pix_y), .o_pix_color(o_pix_color), .o_err(o_err),
        .o_dbg_state(o_dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard monitors
    always @(negedge clk) begin
        if (o_byte_valid) begin
            n_cmp++;
            if (exp_byte_q.size() == 0) begin
                n_fail++;
                $display("FAIL byte: unexpected strobe got %h", {o_byte_is_data, o_byte});
            end else begin
                logic [8:0] e;
                e = exp_byte_q.pop_front();
                if ({o_byte_is_data, o_byte} !== e) begin
                    n_fail++;
                    $display("FAIL byte: got dc/byte %h expected %h", {o_byte_is_data, o_byte}, e);
                end
            end
        end
        if (o_pix_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pixel: unexpected strobe got x/y/c %h", {o_pix_x, o_pix_y, o_pix_color});
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                if ({o_pix_x, o_pix_y, o_pix_color} !== e) begin
                    n_fail++;
                    $display("FAIL pixel: got x/y/c %h expected %h", {o_pix_x, o_pix_y, o_pix_color}, e);
                end
            end
        end
    end

    // driver tasks
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int n);
        cs = 1'b0;
        dc = d;
        for (int i = 0; i < n; i++) begin
            mosi = b[7-i];
            #20 sclk = 1'b1;
            #20 sclk = 1'b0;
        end
    endtask

    task automatic send_byte(input logic d, input logic [7:0] b);
        exp_byte_q.push_back({d, b});
        send_bits(b, d, 8);
        #10 cs = 1'b1;
        #30;
    endtask

    task automatic expect_pix(input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
        exp_q.push_back({x, y, c});
    endtask

    task automatic add_vec(input logic d, input logic [7:0] b, input logic p,
                           input logic [15:0] x, input logic [15:0] y, input logic [15:0] c);
        vec_t v;
        v.dc = d; v.b = b; v.pix = p; v.x = x; v.y = y; v.c = c;
        vecs.push_back(v);
    endtask

    task automatic add_bytes(input logic d, input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) add_vec(d, w[i*8 +: 8], 1'b0, 16'd0, 16'd0, 16'd0);
    endtask

    task automatic check_drained(input string name);
        cycles(20);
        check({name, "_pix_q"}, 48'(exp_q.size()), 48'd0);
        check({name, "_byte_q"}, 48'(exp_byte_q.size()), 48'd0);
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_byte"}, 48'(o_byte), 48'd0);
        check({name, "_byte_valid"}, 48'(o_byte_valid), 48'd0);
        check({name, "_is_data"}, 48'(o_byte_is_data), 48'd0);
        check({name, "_pix_valid"}, 48'(o_pix_valid), 48'd0);
        check({name, "_pix_xyc"}, {o_pix_x, o_pix_y, o_pix_color}, 48'd0);
        check({name, "_err"}, 48'(o_err), 48'd0);
        check({name, "_state"}, 48'(o_dbg_state), 48'd0);
    endtask

    initial begin
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1; dc = 1'b0; lcd_rst = 1'b1;
        cycles(4);
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        cycles(2);

        // command 0xA5, then a data byte in SKIP that must be ignored
        add_vec(1'b0, 8'hA5, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'h99, 1'b0, 16'd0, 16'd0, 16'd0);
        // window 10..11 x 5..6, five red pixels wrapping through the frame
        add_vec(1'b0, 8'h2A, 1'b0, 16'd0, 16'd0, 16'd0);
        add_bytes(1'b1, 32'h000A_000B, 4);
        add_vec(1'b0, 8'h2B, 1'b0, 16'd0, 16'd0, 16'd0);
        add_bytes(1'b1, 32'h0005_0006, 4);
        add_vec(1'b0, 8'h2C, 1'b0, 16'd0, 16'd0, 16'd0);
        for (int i = 0; i < 5; i++) begin
            add_vec(1'b1, 8'hF8, 1'b0, 16'd0, 16'd0, 16'd0);
            add_vec(1'b1, 8'h00, 1'b1, (i % 2 == 0) ? 16'd10 : 16'd11,
                    (i == 1 || i == 4) ? 16'd5 : ((i == 0) ? 16'd5 : 16'd6), 16'hF800);
        end
        // pending high byte dropped by an intervening command
        add_vec(1'b0, 8'h2C, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'hAB, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b0, 8'h00, 1'b0, 16'd0, 16'd0, 16'd0);
        add_bytes(1'b1, 32'h0000_1234, 2);
        // inverted window SC > EC: x keeps counting past EC
        add_vec(1'b0, 8'h2A, 1'b0, 16'd0, 16'd0, 16'd0);
        add_bytes(1'b1, 32'h0005_0003, 4);
        add_vec(1'b0, 8'h2B, 1'b0, 16'd0, 16'd0, 16'd0);
        add_bytes(1'b1, 32'h0002_0002, 4);
        add_vec(1'b0, 8'h2C, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'h11, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'h22, 1'b1, 16'd5, 16'd2, 16'h1122);
        add_vec(1'b1, 8'h33, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'h44, 1'b1, 16'd6, 16'd2, 16'h3344);
        add_vec(1'b1, 8'hAA, 1'b0, 16'd0, 16'd0, 16'd0);
        add_vec(1'b1, 8'h55, 1'b1, 16'd7, 16'd2, 16'hAA55);

        foreach (vecs[i]) begin
            if (vecs[i].pix) expect_pix(vecs[i].x, vecs[i].y, vecs[i].c);
            send_byte(vecs[i].dc, vecs[i].b);
        end
        check_drained("table");

        // after reset, default window origin
        rst = 1'b1; cycles(2); rst = 1'b0; cycles(2);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h12);
        expect_pix(16'd0, 16'd0, 16'h1234);
        send_byte(1'b1, 8'h34);
        check_drained("after_reset");

        // truncated byte sets the sticky error, next byte decodes cleanly
        check("err_before", 48'(o_err), 48'd0);
        send_bits(8'hE0, 1'b0, 3);
        #10 cs = 1'b1;
        cycles(6);
        check("err_set", 48'(o_err), 48'd1);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h56);
        expect_pix(16'd0, 16'd0, 16'h5678);
        send_byte(1'b1, 8'h78);
        check_drained("after_err");

        // display reset restores the window but keeps the error flag
        send_byte(1'b0, 8'h2A);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
        send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
        lcd_rst = 1'b0; cycles(5); lcd_rst = 1'b1; cycles(5);
        check("lcd_rst_err_kept", 48'(o_err), 48'd1);
        check("lcd_rst_state", 48'(o_dbg_state), 48'd0);
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'h01);
        expect_pix(16'd0, 16'd0, 16'h0102);
        send_byte(1'b1, 8'h02);
        check_drained("lcd_rst");

        // system reset in the middle of a pixel's low byte
        send_byte(1'b0, 8'h2C);
        send_byte(1'b1, 8'hAB);
        send_bits(8'hCD, 1'b1, 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_all_zero("mid_rst");
        #2 rst = 1'b0;
        cs = 1'b1;
        check_drained("mid_rst");

        // 241 pixels: the default column end 239 wraps to the next page
        send_byte(1'b0, 8'h2C);
        for (int i = 0; i <= 240; i++) begin
            logic [15:0] v;
            v = 16'(i * 7 + 3);
            send_byte(1'b1, v[15:8]);
            expect_pix((i < 240) ? 16'(i) : 16'd0, (i < 240) ? 16'd0 : 16'd1, v);
            send_byte(1'b1, v[7:0]);
        end
        check_drained("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
